pc_fetch: RTL

Program-counter register and instruction-fetch sequencer for the 16-bit datapath. It holds the architectural PC, drives it to the PC ALU, and reads the instruction at that PC from instruction memory over a ready handshake. It presents the instruction to decode and loads the PC ALU's next-PC result when decode accepts the instruction. A redirect input lets the controller force a new PC and discard the instruction in flight.

---
 rtl/pc_fetch.sv | 91 +++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer. Fetches the word at pc over a
// ready handshake, holds it for decode, and advances pc on accept or redirect.
module pc_fetch #(
  parameter int unsigned     WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] next_pc,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  input  logic             instr_ack,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StHold  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;

    // Redirect outranks both the memory response and decode's accept.
    if (redirect) begin
      pc_d          = redirect_pc;
      instr_valid_d = 1'b0;
      state_d       = StFetch;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StFetch;
        end
        StFetch: begin
          if (mem_ready) begin
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
            state_d       = StHold;
          end
        end
        StHold: begin
          if (instr_ack) begin
            pc_d          = next_pc;
            instr_valid_d = 1'b0;
            state_d       = StFetch;
          end
        end
        default: begin
          instr_valid_d = 1'b0;
          state_d       = StIdle;
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign mem_req     = (state_q == StFetch);
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;

endmodule
